dds_sweep_controller: RTL

DDS_SWEEP_CONTROLLER -- requirements
Module: dds_sweep_controller

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_dwell_timer.sv | 29 ++
 rtl/dds_sweep_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS datapath it feeds.
package dds_pkg;

  // Default widths, kept equal to the downstream DDS phase accumulator.
  localparam int DEFAULT_PHASE_WIDTH = 24;
  localparam int DEFAULT_DWELL_WIDTH = 16;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Down-counting dwell timer. The controller loads it on every fcw strobe with
// the dwell length; expire marks the last DWELL cycle, so the STEP cycle that
// follows closes a hold period of exactly dwell+1 cycles.
module dds_dwell_timer #(
  parameter int WIDTH = dds_pkg::DEFAULT_DWELL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/dds_sweep_controller.sv
// Frequency sweep controller: steps a DDS frequency control word between two
// bounds, holding each value for a programmable dwell, in sawtooth or
// triangle shape, single pass or continuous.
module dds_sweep_controller
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_stop,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic                   triangle,
  input  logic                   continuous,
  output logic [PHASE_WIDTH-1:0] fcw,
  output logic                   fcw_strobe,
  output logic                   busy,
  output logic                   done,
  output logic                   sweep_dir
);

  state_t state, state_next;

  // Configuration captured at start; inputs are ignored until the next start.
  logic [PHASE_WIDTH-1:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_triangle, cfg_continuous;

  logic [PHASE_WIDTH-1:0] fcw_next, emit_value;
  logic [DWELL_WIDTH-1:0] hold_len;
  logic strobe_next, busy_next, done_next, dir_next;
  logic cfg_load, timer_load, emit, finish, expire, degenerate;

  // Step up toward an upper bound; the extra carry bit catches wrap-around.
  function automatic logic [PHASE_WIDTH-1:0] step_up(
    input logic [PHASE_WIDTH-1:0] from, step, bound);
    logic [PHASE_WIDTH:0] sum;
    sum = {1'b0, from} + {1'b0, step};
    return (sum >= {1'b0, bound}) ? bound : sum[PHASE_WIDTH-1:0];
  endfunction

  // Step down toward a lower bound; the borrow bit catches underflow.
  function automatic logic [PHASE_WIDTH-1:0] step_down(
    input logic [PHASE_WIDTH-1:0] from, step, bound);
    logic [PHASE_WIDTH:0] diff;
    diff = {1'b0, from} - {1'b0, step};
    return (diff[PHASE_WIDTH] || diff[PHASE_WIDTH-1:0] <= bound) ? bound
                                                                 : diff[PHASE_WIDTH-1:0];
  endfunction

  // A zero step or an empty range just parks on f_start.
  assign degenerate = (cfg_f_step == '0) || (cfg_f_start >= cfg_f_stop);

  // On the start edge the dwell input is being latched, so use it directly.
  assign hold_len = cfg_load ? dwell : cfg_dwell;

  dds_dwell_timer #(
    .WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(hold_len),
    .expire    (expire)
  );

  // Next-state and next-output decision; abort overrides everything.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned
    // and a latch is never inferred.
    state_next  = state;
    fcw_next    = fcw;
    strobe_next = 1'b0;
    busy_next   = busy;
    done_next   = 1'b0;
    dir_next    = sweep_dir;
    cfg_load    = 1'b0;
    timer_load  = 1'b0;
    emit        = 1'b0;
    emit_value  = fcw;
    finish      = 1'b0;

    if (abort) begin
      state_next = IDLE;
      busy_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_load   = 1'b1;
            emit       = 1'b1;
            emit_value = f_start;
            dir_next   = 1'b0;
            busy_next  = 1'b1;
          end
        end
        DWELL: begin
          if (expire) state_next = STEP;
        end
        STEP: begin
          if (degenerate) begin
            if (cfg_continuous) begin
              emit       = 1'b1;
              emit_value = cfg_f_start;
            end else begin
              finish = 1'b1;
            end
          end else if (!sweep_dir) begin
            if (fcw == cfg_f_stop) begin
              if (cfg_triangle) begin
                dir_next   = 1'b1;
                emit       = 1'b1;
                emit_value = step_down(fcw, cfg_f_step, cfg_f_start);
              end else if (cfg_continuous) begin
                emit       = 1'b1;
                emit_value = cfg_f_start;
              end else begin
                finish = 1'b1;
              end
            end else begin
              emit       = 1'b1;
              emit_value = step_up(fcw, cfg_f_step, cfg_f_stop);
            end
          end else begin
            // Descending only happens in triangle mode; f_start ends a pass.
            if (fcw == cfg_f_start) begin
              if (cfg_continuous) begin
                dir_next   = 1'b0;
                emit       = 1'b1;
                emit_value = step_up(fcw, cfg_f_step, cfg_f_stop);
              end else begin
                finish = 1'b1;
              end
            end else begin
              emit       = 1'b1;
              emit_value = step_down(fcw, cfg_f_step, cfg_f_start);
            end
          end
        end
        default: state_next = IDLE;
      endcase

      // A new fcw restarts the hold; a zero dwell goes straight to STEP.
      if (emit) begin
        fcw_next    = emit_value;
        strobe_next = 1'b1;
        timer_load  = 1'b1;
        state_next  = (hold_len == '0) ? STEP : DWELL;
      end

      if (finish) begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      fcw        <= '0;
      fcw_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sweep_dir  <= 1'b0;
    end else begin
      state      <= state_next;
      fcw        <= fcw_next;
      fcw_strobe <= strobe_next;
      busy       <= busy_next;
      done       <= done_next;
      sweep_dir  <= dir_next;
    end
  end

  // Configuration latch, loaded only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are plain registers, not a RAM, so they take a reset value;
    // a configuration left over from before reset can never leak into a sweep.
    if (rst) begin
      cfg_f_start    <= '0;
      cfg_f_stop     <= '0;
      cfg_f_step     <= '0;
      cfg_dwell      <= '0;
      cfg_triangle   <= 1'b0;
      cfg_continuous <= 1'b0;
    end else if (cfg_load) begin
      cfg_f_start    <= f_start;
      cfg_f_stop     <= f_stop;
      cfg_f_step     <= f_step;
      cfg_dwell      <= dwell;
      cfg_triangle   <= triangle;
      cfg_continuous <= continuous;
    end
  end

endmodule
